// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths and run-profiler FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Default widths shared by the cycle counter and the run profiler
  localparam int CC_W  = 16;
  localparam int RET_W = 16;

  // Run-profiler FSM states
  typedef enum logic [1:0] {
    PROF_IDLE   = 2'd0,
    PROF_RUN    = 2'd1,
    PROF_REPORT = 2'd2
  } prof_state_t;

endpackage
`default_nettype wire

// File: rtl/run_profiler_if.sv
`default_nettype none
// ============================================================================
// Module   : run_profiler_if
// Brief    : Result-record channel from the run profiler to the reporting logic.
// Revision : 1.0 - initial release
// ============================================================================
interface run_profiler_if
  import cpu_pkg::*;
#(
  parameter int CNT_W = CC_W,
  parameter int RET_W = cpu_pkg::RET_W
);

  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_cycles;
  logic [RET_W-1:0] rpt_instrs;
  logic             rpt_sat;

  // Profiler side: produces the record
  modport master (
    output rpt_valid,
    output rpt_cycles,
    output rpt_instrs,
    output rpt_sat,
    input  rpt_ready
  );

  // Consumer side: reporting/display logic
  modport slave (
    input  rpt_valid,
    input  rpt_cycles,
    input  rpt_instrs,
    input  rpt_sat,
    output rpt_ready
  );

endinterface
`default_nettype wire

// File: rtl/run_profiler_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with clear, enable and sticky saturation
//            flag. Exposes the look-ahead value (what the counter will hold
//            after this edge) so a capture can include this cycle's increment.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt_next,
  output logic         sat_next
);

  localparam logic [W-1:0] c_max = '1;
  localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;
  logic         r_sat;

  // Next count: clear wins, otherwise increment until the ceiling, then flag
  always_comb begin
    cnt_next = r_cnt;
    sat_next = r_sat;
    if (clr) begin
      cnt_next = '0;
      sat_next = 1'b0;
    end else if (en) begin
      if (r_cnt == c_max) begin
        sat_next = 1'b1;
      end else begin
        cnt_next = r_cnt + c_one;
      end
    end
  end

  // Count and sticky flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= cnt_next;
      r_sat <= sat_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/run_profiler.sv
`default_nettype none
// ============================================================================
// Module   : run_profiler
// Brief    : Measures one program run: elapsed cycles (from the free-running
//            cycle counter) and retired instructions, reported as one record
//            per run over a valid/ready channel.
// Revision : 1.0 - initial release
// ============================================================================
module run_profiler
  import cpu_pkg::*;
#(
  parameter int CNT_W = CC_W,
  parameter int RET_W = cpu_pkg::RET_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cc_count,
  input  logic             start,
  input  logic             retire,
  input  logic             halt,
  output logic             busy,
  run_profiler_if.master   rpt
);

  prof_state_t      r_state;
  prof_state_t      w_state_nxt;
  logic             w_take_start;
  logic             w_take_halt;
  logic             w_cnt_en;
  logic [RET_W-1:0] w_ret_cnt_nxt;
  logic             w_ret_sat_nxt;

  logic [CNT_W-1:0] r_start_cc;
  logic [CNT_W-1:0] r_cycles;
  logic [RET_W-1:0] r_instrs;
  logic             r_rpt_sat;
  logic             r_valid;
  logic             r_busy;

  // Retire counter; the look-ahead value already includes a retire on the halt cycle
  sat_counter #(
    .W (RET_W)
  ) u_ret_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_take_start),
    .en       (w_cnt_en),
    .cnt_next (w_ret_cnt_nxt),
    .sat_next (w_ret_sat_nxt)
  );

  // Next state and qualified events; start only counts in IDLE, halt only in RUN
  always_comb begin
    w_state_nxt  = r_state;
    w_take_start = 1'b0;
    w_take_halt  = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      PROF_IDLE: begin
        if (start) begin
          w_take_start = 1'b1;
          w_state_nxt  = PROF_RUN;
        end
      end
      PROF_RUN: begin
        w_cnt_en = retire;
        if (halt) begin
          w_take_halt = 1'b1;
          w_state_nxt = PROF_REPORT;
        end
      end
      PROF_REPORT: begin
        if (rpt.rpt_ready) begin
          w_state_nxt = PROF_IDLE;
        end
      end
      default: w_state_nxt = PROF_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PROF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered state decodes so valid and busy have no input-to-output path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == PROF_REPORT);
      r_busy  <= (w_state_nxt != PROF_IDLE);
    end
  end

  // Capture start stamp and, at halt, the record; the record then holds until the next halt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_cc <= '0;
      r_cycles   <= '0;
      r_instrs   <= '0;
      r_rpt_sat  <= 1'b0;
    end else begin
      if (w_take_start) begin
        r_start_cc <= cc_count;
      end
      if (w_take_halt) begin
        r_cycles  <= cc_count - r_start_cc;
        r_instrs  <= w_ret_cnt_nxt;
        r_rpt_sat <= w_ret_sat_nxt;
      end
    end
  end

  assign rpt.rpt_valid  = r_valid;
  assign rpt.rpt_cycles = r_cycles;
  assign rpt.rpt_instrs = r_instrs;
  assign rpt.rpt_sat    = r_rpt_sat;
  assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_run_profiler.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_profiler
// Brief    : Scoreboard bench for run_profiler. Two instances share stimulus:
//            one with 16-bit retire counter, one with a 4-bit retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_profiler;
  import cpu_pkg::*;

  typedef struct {
    logic [15:0] cyc;
    logic [15:0] ins;
    logic        sat;
  } rec_t;

  logic        clk;
  logic        rst;
  logic [15:0] cc_count;
  logic        start;
  logic        retire;
  logic        halt;
  logic        rpt_ready;
  logic        busy_a;
  logic        busy_4;

  int checks;
  int errors;

  rec_t qa[$];
  rec_t q4[$];

  run_profiler_if #(.CNT_W(16), .RET_W(16)) if_a ();
  run_profiler_if #(.CNT_W(16), .RET_W(4))  if_4 ();

  assign if_a.rpt_ready = rpt_ready;
  assign if_4.rpt_ready = rpt_ready;

  run_profiler #(.CNT_W(16), .RET_W(16)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .cc_count (cc_count),
    .start    (start),
    .retire   (retire),
    .halt     (halt),
    .busy     (busy_a),
    .rpt      (if_a)
  );

  run_profiler #(.CNT_W(16), .RET_W(4)) u_dut_4 (
    .clk      (clk),
    .rst      (rst),
    .cc_count (cc_count),
    .start    (start),
    .retire   (retire),
    .halt     (halt),
    .busy     (busy_4),
    .rpt      (if_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the edge
  task automatic step(input logic s, input logic r, input logic h, input logic [15:0] cc);
    start    = s;
    retire   = r;
    halt     = h;
    cc_count = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic retires(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic exp_rec(input logic [15:0] c, input logic [15:0] ia,
                         input logic [15:0] i4, input logic s4);
    rec_t ea;
    rec_t e4;
    ea.cyc = c; ea.ins = ia; ea.sat = 1'b0;
    e4.cyc = c; e4.ins = i4; e4.sat = s4;
    qa.push_back(ea);
    q4.push_back(e4);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_async_busy",   32'(busy_a), 32'h0);
    chk("rst_async_valid",  32'(if_a.rpt_valid), 32'h0);
    chk("rst_async_cycles", 32'(if_a.rpt_cycles), 32'h0);
    chk("rst_async_instrs", 32'(if_a.rpt_instrs), 32'h0);
    chk("rst_async_sat4",   32'(if_4.rpt_sat), 32'h0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the 16-bit instance
  always @(negedge clk) begin : mon_a
    rec_t e;
    if (!rst && if_a.rpt_valid && if_a.rpt_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_record actual=%0h required=none", if_a.rpt_cycles);
      end else begin
        e = qa.pop_front();
        chk("a_cycles", 32'(if_a.rpt_cycles), 32'(e.cyc));
        chk("a_instrs", 32'(if_a.rpt_instrs), 32'(e.ins));
        chk("a_sat",    32'(if_a.rpt_sat),    32'(e.sat));
      end
    end
  end

  // Scoreboard monitor for the 4-bit instance
  always @(negedge clk) begin : mon_4
    rec_t e;
    if (!rst && if_4.rpt_valid && if_4.rpt_ready) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w4_unexpected_record actual=%0h required=none", if_4.rpt_cycles);
      end else begin
        e = q4.pop_front();
        chk("w4_cycles", 32'(if_4.rpt_cycles), 32'(e.cyc));
        chk("w4_instrs", 32'(if_4.rpt_instrs), 32'(e.ins));
        chk("w4_sat",    32'(if_4.rpt_sat),    32'(e.sat));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    rpt_ready = 1'b1;
    start     = 1'b0;
    retire    = 1'b0;
    halt      = 1'b0;
    cc_count  = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_busy",   32'(busy_a), 32'h0);
    chk("reset_valid",  32'(if_a.rpt_valid), 32'h0);
    chk("reset_cycles", 32'(if_a.rpt_cycles), 32'h0);
    chk("reset_instrs", 32'(if_a.rpt_instrs), 32'h0);
    chk("reset_sat",    32'(if_a.rpt_sat), 32'h0);

    // Basic run: 5 -> 25, 7 retires
    step(1'b1, 1'b0, 1'b0, 16'd5);
    chk("basic_busy_after_start", 32'(busy_a), 32'h1);
    retires(7);
    chk("basic_no_valid_in_run", 32'(if_a.rpt_valid), 32'h0);
    exp_rec(16'd20, 16'd7, 16'd7, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'd25);
    chk("basic_halt_latency", 32'(if_a.rpt_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 16'd26);
    chk("basic_valid_dropped", 32'(if_a.rpt_valid), 32'h0);
    chk("basic_busy_idle", 32'(busy_a), 32'h0);
    chk("basic_data_kept", 32'(if_a.rpt_cycles), 32'd20);

    // Wrap-around of the cycle counter
    step(1'b1, 1'b0, 1'b0, 16'hFFF0);
    retires(2);
    exp_rec(16'h0020, 16'd2, 16'd2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0010);
    step(1'b0, 1'b0, 1'b0, 16'h0011);

    // start and halt together in IDLE: start wins, no report
    step(1'b1, 1'b0, 1'b1, 16'd100);
    chk("simul_busy", 32'(busy_a), 32'h1);
    chk("simul_no_valid", 32'(if_a.rpt_valid), 32'h0);
    retires(3);
    exp_rec(16'd10, 16'd4, 16'd4, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'd110);
    step(1'b0, 1'b0, 1'b0, 16'd111);

    // Backpressure with input noise in REPORT
    rpt_ready = 1'b0;
    step(1'b1, 1'b0, 1'b0, 16'd200);
    retires(5);
    exp_rec(16'd30, 16'd5, 16'd5, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'd230);
    for (int i = 0; i < 10; i++) begin
      step(i[0], i[1], i[2] ^ i[0], 16'(i * 37));
      chk("bp_valid_held", 32'(if_a.rpt_valid), 32'h1);
      chk("bp_cycles_held", 32'(if_a.rpt_cycles), 32'd30);
      chk("bp_instrs_held", 32'(if_a.rpt_instrs), 32'd5);
      chk("bp_busy_held", 32'(busy_a), 32'h1);
    end
    rpt_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'd0);
    chk("bp_valid_after_hs", 32'(if_a.rpt_valid), 32'h0);
    chk("bp_busy_after_hs", 32'(busy_a), 32'h0);

    // Saturation on the 4-bit instance: 20 retires, halt without retire
    step(1'b1, 1'b0, 1'b0, 16'd300);
    retires(20);
    exp_rec(16'd30, 16'd20, 16'd15, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'd330);
    step(1'b0, 1'b0, 1'b0, 16'd331);

    // Saturation caused by the retire on the halt cycle
    step(1'b1, 1'b0, 1'b0, 16'd400);
    retires(15);
    exp_rec(16'd16, 16'd16, 16'd15, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'd416);
    step(1'b0, 1'b0, 1'b0, 16'd417);

    // Reaching exactly the ceiling does not flag saturation
    step(1'b1, 1'b0, 1'b0, 16'd500);
    retires(14);
    exp_rec(16'd15, 16'd15, 16'd15, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'd515);
    step(1'b0, 1'b0, 1'b0, 16'd516);

    // Reset while in RUN, then a fresh run
    step(1'b1, 1'b0, 1'b0, 16'd600);
    retires(3);
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 16'd700);
    retires(2);
    exp_rec(16'd5, 16'd2, 16'd2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'd705);
    step(1'b0, 1'b0, 1'b0, 16'd706);

    // Reset while in REPORT drops the pending record
    rpt_ready = 1'b0;
    step(1'b1, 1'b0, 1'b0, 16'd800);
    retires(1);
    step(1'b0, 1'b0, 1'b1, 16'd810);
    chk("rr_pending_valid", 32'(if_a.rpt_valid), 32'h1);
    chk("rr_pending_cycles", 32'(if_a.rpt_cycles), 32'd10);
    pulse_reset();
    rpt_ready = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'd900);
    retires(3);
    exp_rec(16'd4, 16'd3, 16'd3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'd904);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'd905);

    chk("a_queue_drained", 32'(qa.size()), 32'h0);
    chk("w4_queue_drained", 32'(q4.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_profiler.md
# run_profiler

Measures one program run on the RISC-V core and reports elapsed clock cycles and retired-instruction count. Sits directly downstream of the free-running clock-cycle counter: it samples that counter's `cc_count` at program start and at halt. It counts retire strobes from the writeback stage in between. It hands one result record per run to the reporting/display logic through a valid/ready handshake.

## Interface
Parameters:
- `CNT_W`, default 16: width of `cc_count` and `rpt_cycles`. Must match the cycle counter.
- `RET_W`, default 16: width of the retired-instruction counter and `rpt_instrs`.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `cc_count`, input, `CNT_W`: current cycle count from the cycle counter.
- `start`, input, 1: program-start indication. Level or pulse; only sampled in IDLE.
- `retire`, input, 1: one instruction retired this cycle.
- `halt`, input, 1: program reached its terminating instruction (ecall/ebreak). Only sampled in RUN.
- `rpt_ready`, input, 1: consumer accepts the record.
- `rpt_valid`, output, 1: record valid.
- `rpt_cycles`, output, `CNT_W`: elapsed cycles, start to halt.
- `rpt_instrs`, output, `RET_W`: retired instructions.
- `rpt_sat`, output, 1: retire counter saturated during the run.
- `busy`, output, 1: high in RUN or REPORT.

## Operation
- FSM states are IDLE, RUN and REPORT.
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - Internal `start_cc`, `ret_cnt` and `sat` are 0.
- IDLE:
  - On `start`=1: latch `start_cc`←`cc_count`, clear `ret_cnt` and `sat`, then go to RUN.
  - `retire` and `halt` are ignored in IDLE.
  - If `start` and `halt` are high in the same IDLE cycle, `start` wins and `halt` is ignored.
- RUN:
  - Each cycle with `retire`=1, `ret_cnt` increments by 1.
  - `ret_cnt` saturates at 2^RET_W−1. A retire at saturation sets `sat`=1 and the count holds.
  - `start` is ignored in RUN.
  - On `halt`=1:
    - `rpt_cycles` ← (`cc_count` − `start_cc`) mod 2^CNT_W. Unsigned subtraction, so counter wrap-around is handled implicitly. Runs longer than 2^CNT_W cycles alias, and this is not detected.
    - `rpt_instrs` ← `ret_cnt` plus this cycle's `retire`, saturating.
    - `rpt_sat` ← `sat` OR saturation caused this cycle.
    - Next state is REPORT.
- REPORT:
  - `rpt_valid`=1.
  - `rpt_cycles`, `rpt_instrs` and `rpt_sat` are held stable until the handshake.
  - On `rpt_valid`&&`rpt_ready`: go to IDLE and drop `rpt_valid`. Data outputs keep their last value.
  - `start`, `retire` and `halt` are ignored in REPORT. A `start` still high on the cycle after returning to IDLE begins a new run.
- `busy` is 1 exactly when state is RUN or REPORT. It is a registered state decode.
- Reset in any state returns to IDLE immediately and clears all outputs, whether or not a record is pending. A pending record is lost.

## Timing
- Start latency:
  - `start` sampled at edge N means the state is RUN and `busy`=1 after edge N.
  - `start_cc` holds the `cc_count` value present before edge N.
  - The first countable `retire` is the one sampled at edge N+1.
- Halt latency:
  - `halt` sampled at edge M means `rpt_valid`=1 after edge M, one cycle of latency.
  - The `retire` sampled at edge M is counted.
- Handshake:
  - `rpt_valid` stays high until a rising edge with `rpt_ready`=1.
  - The minimum REPORT residency is 1 cycle, when `rpt_ready` is already high.
  - `rpt_valid` does not depend combinationally on `rpt_ready`.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared package `cpu_pkg`:
  - FSM state encoding (`PROF_IDLE`, `PROF_RUN`, `PROF_REPORT`).
  - Default widths `CC_W`=16 and `RET_W`=16, used by both the cycle counter and this block.
- One natural sub-module: `sat_counter`, a parameterised saturating up-counter with clear, enable and a sticky saturation flag. It is used for `ret_cnt`.
- The rest is a single FSM plus capture registers in `run_profiler`.

## Test plan
- Basic run:
  - Stimulus: `start` with `cc_count`=5, 7 retire pulses, `halt` with `cc_count`=25.
  - Required response: `rpt_valid` 1 cycle later with `rpt_cycles`=20, `rpt_instrs`=7, `rpt_sat`=0.
- Wrap-around:
  - Stimulus: start at `cc_count`=0xFFF0, halt at `cc_count`=0x0010.
  - Required response: `rpt_cycles`=0x0020.
- Backpressure:
  - Stimulus: hold `rpt_ready`=0 for 10 cycles while toggling `start`, `retire` and `halt`.
  - Required response: record unchanged and `rpt_valid` held. On `rpt_ready`=1, one handshake occurs, then IDLE with `busy`=0.
- Simultaneous events:
  - Stimulus: `start` and `halt` in the same IDLE cycle.
  - Required response: goes to RUN with no report.
  - Stimulus: `retire` and `halt` in the same RUN cycle after 3 prior retires.
  - Required response: `rpt_instrs`=4.
- Saturation (`RET_W`=4):
  - Stimulus: 20 retires, then `halt`.
  - Required response: `rpt_instrs`=15, `rpt_sat`=1.
- Reset mid-operation:
  - Stimulus: assert `rst` asynchronously in RUN, and separately in REPORT.
  - Required response: outputs go to 0 without waiting for a clock edge and the state returns to IDLE. The next run reports fresh values.
